// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: owns the PC, the IF/ID register and the control half of
// the ID/EX register. It applies the hazard unit's keep, bubble and branch-flush
// requests to them, counts stalls and flushes, and flags inconsistent stall
// requests. Every output is registered, so no input reaches an output combinationally.
module pipeline_stall_ctrl #(
    parameter int              DATA_WIDTH = 32,
    parameter int              CTRL_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0] PC_RESET = '0,
    parameter int              CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pc_keep_i,
    input  logic                  IF_ID_keep_i,
    input  logic                  ID_EX_zero_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    input  logic [CTRL_WIDTH-1:0] ID_ctrl_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] IF_ID_pc_o,
    output logic [DATA_WIDTH-1:0] IF_ID_instr_o,
    output logic                  IF_ID_valid_o,
    output logic [CTRL_WIDTH-1:0] ID_EX_ctrl_o,
    output logic                  ID_EX_valid_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o,
    output logic                  keep_err_o
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_if_id_pc;
    logic [DATA_WIDTH-1:0] r_if_id_instr;
    logic                  r_if_id_valid;
    logic [CTRL_WIDTH-1:0] r_id_ex_ctrl;
    logic                  r_id_ex_valid;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;
    logic                  r_keep_err;

    logic                  w_stall;
    logic                  w_flush;
    logic                  w_bubble;
    logic                  w_keep_mismatch;
    logic [DATA_WIDTH-1:0] w_pc_plus4;

    // A half-asserted keep request is treated as a full stall, so the PC and
    // IF/ID always stay in step. A branch seen during a stall is ignored
    // because ID re-presents it once its operands are valid.
    assign w_stall         = pc_keep_i | IF_ID_keep_i;
    assign w_flush         = branch_taken_i & ~w_stall;
    assign w_bubble        = ID_EX_zero_i | w_stall | ~r_if_id_valid;
    assign w_keep_mismatch = (pc_keep_i != IF_ID_keep_i) | (pc_keep_i != ID_EX_zero_i);
    assign w_pc_plus4      = r_pc + DATA_WIDTH'(4);   // wraps modulo 2^DATA_WIDTH

    // PC: hold on stall, redirect on a taken branch, otherwise advance sequentially
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc <= PC_RESET;
        end else if (w_stall) begin
            r_pc <= r_pc;
        end else if (branch_taken_i) begin
            r_pc <= branch_target_i;
        end else begin
            r_pc <= w_pc_plus4;
        end
    end

    // IF/ID: hold on stall, flush on a taken branch, otherwise capture the fetch
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end else if (w_stall) begin
            r_if_id_pc    <= r_if_id_pc;
            r_if_id_instr <= r_if_id_instr;
            r_if_id_valid <= r_if_id_valid;
        end else if (branch_taken_i) begin
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_if_id_pc    <= w_pc_plus4;
            r_if_id_instr <= imem_instr_i;
            r_if_id_valid <= 1'b1;
        end
    end

    // ID/EX control: never holds; a stall or an empty ID slot drains EX as a bubble
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_id_ex_ctrl  <= '0;
            r_id_ex_valid <= 1'b0;
        end else if (w_bubble) begin
            r_id_ex_ctrl  <= '0;
            r_id_ex_valid <= 1'b0;
        end else begin
            r_id_ex_ctrl  <= ID_ctrl_i;
            r_id_ex_valid <= 1'b1;
        end
    end

    // Saturating stall and flush counters
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (w_flush && (r_flush_cnt != {CNT_WIDTH{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Sticky flag: the three stall request lines disagreed at some point
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_keep_err <= 1'b0;
        end else if (w_keep_mismatch) begin
            r_keep_err <= 1'b1;
        end
    end

    assign pc_o          = r_pc;
    assign IF_ID_pc_o    = r_if_id_pc;
    assign IF_ID_instr_o = r_if_id_instr;
    assign IF_ID_valid_o = r_if_id_valid;
    assign ID_EX_ctrl_o  = r_id_ex_ctrl;
    assign ID_EX_valid_o = r_id_ex_valid;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;
    assign keep_err_o    = r_keep_err;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: sequential fetch, load-use stall,
// branch flush, stall/branch collision, inconsistent keep requests with async
// reset, counter saturation and PC wrap.
module tb_pipeline_stall_ctrl;

    localparam int DW = 32;
    localparam int CW = 12;
    localparam int NW = 16;
    localparam logic [CW-1:0] CTRL_VAL = 12'h5A3;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          pc_keep_i, IF_ID_keep_i, ID_EX_zero_i, branch_taken_i;
    logic [DW-1:0] branch_target_i;
    logic [DW-1:0] imem_instr_i;
    logic [CW-1:0] ID_ctrl_i;
    logic [DW-1:0] pc_o, IF_ID_pc_o, IF_ID_instr_o;
    logic          IF_ID_valid_o, ID_EX_valid_o, keep_err_o;
    logic [CW-1:0] ID_EX_ctrl_o;
    logic [NW-1:0] stall_cnt_o, flush_cnt_o;

    int vectors = 0;
    int errors  = 0;

    pipeline_stall_ctrl #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .PC_RESET(32'h0), .CNT_WIDTH(NW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .pc_keep_i(pc_keep_i), .IF_ID_keep_i(IF_ID_keep_i), .ID_EX_zero_i(ID_EX_zero_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .imem_instr_i(imem_instr_i), .ID_ctrl_i(ID_ctrl_i),
        .pc_o(pc_o), .IF_ID_pc_o(IF_ID_pc_o), .IF_ID_instr_o(IF_ID_instr_o),
        .IF_ID_valid_o(IF_ID_valid_o), .ID_EX_ctrl_o(ID_EX_ctrl_o), .ID_EX_valid_o(ID_EX_valid_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .keep_err_o(keep_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational instruction memory model: a fixed scramble of the address
    function automatic logic [DW-1:0] imem(input logic [DW-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr_i = imem(pc_o);

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_stall(input logic pk, input logic ik, input logic ez);
        pc_keep_i    = pk;
        IF_ID_keep_i = ik;
        ID_EX_zero_i = ez;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        set_stall(1'b0, 1'b0, 1'b0);
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        ID_ctrl_i       = CTRL_VAL;
        step();
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (pc_o !== 32'h0 || IF_ID_pc_o !== 32'h0 || IF_ID_instr_o !== 32'h0 || IF_ID_valid_o !== 1'b0 ||
            ID_EX_ctrl_o !== '0 || ID_EX_valid_o !== 1'b0 || stall_cnt_o !== '0 || flush_cnt_o !== '0 ||
            keep_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h ifpc=%h ifinstr=%h ifv=%b ctrl=%h exv=%b sc=%0d fc=%0d err=%b, required all zero",
                     pc_o, IF_ID_pc_o, IF_ID_instr_o, IF_ID_valid_o, ID_EX_ctrl_o, ID_EX_valid_o,
                     stall_cnt_o, flush_cnt_o, keep_err_o);
        end
        $display("reset: pc=%h ifv=%b exv=%b", pc_o, IF_ID_valid_o, ID_EX_valid_o);
    endtask

    task automatic test_sequential();
        logic [DW-1:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            step();
            exp_pc = DW'(4 * c);
            vectors++;
            if (pc_o !== exp_pc || IF_ID_valid_o !== 1'b1 || IF_ID_pc_o !== exp_pc ||
                IF_ID_instr_o !== imem(exp_pc - 32'd4)) begin
                errors++;
                $display("FAIL seq_fetch c%0d: pc=%h ifpc=%h instr=%h v=%b, required pc=%h ifpc=%h instr=%h v=1",
                         c, pc_o, IF_ID_pc_o, IF_ID_instr_o, IF_ID_valid_o, exp_pc, exp_pc, imem(exp_pc - 32'd4));
            end
            vectors++;
            if (ID_EX_valid_o !== (c >= 2) || ID_EX_ctrl_o !== ((c >= 2) ? CTRL_VAL : 12'h0)) begin
                errors++;
                $display("FAIL seq_idex c%0d: exv=%b ctrl=%h, required exv=%b", c, ID_EX_valid_o, ID_EX_ctrl_o, c >= 2);
            end
            $display("seq c%0d: pc=%h ifv=%b exv=%b", c, pc_o, IF_ID_valid_o, ID_EX_valid_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        step(); step();
        set_stall(1'b1, 1'b1, 1'b1);
        step();
        set_stall(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pc_o !== 32'd8 || IF_ID_instr_o !== imem(32'd4) || IF_ID_pc_o !== 32'd8 ||
            ID_EX_valid_o !== 1'b0 || ID_EX_ctrl_o !== '0 || stall_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL load_use_stall: pc=%h instr=%h exv=%b ctrl=%h sc=%0d, required pc=8 instr=%h exv=0 ctrl=0 sc=1",
                     pc_o, IF_ID_instr_o, ID_EX_valid_o, ID_EX_ctrl_o, stall_cnt_o, imem(32'd4));
        end
        $display("load_use stall: pc=%h exv=%b sc=%0d", pc_o, ID_EX_valid_o, stall_cnt_o);
        step();
        vectors++;
        if (pc_o !== 32'd12 || IF_ID_instr_o !== imem(32'd8) || ID_EX_valid_o !== 1'b1 ||
            stall_cnt_o !== 16'd1 || keep_err_o !== 1'b0) begin
            errors++;
            $display("FAIL load_use_resume: pc=%h instr=%h exv=%b sc=%0d err=%b, required pc=c instr=%h exv=1 sc=1 err=0",
                     pc_o, IF_ID_instr_o, ID_EX_valid_o, stall_cnt_o, keep_err_o, imem(32'd8));
        end
        $display("load_use resume: pc=%h exv=%b", pc_o, ID_EX_valid_o);
    endtask

    task automatic test_branch_flush();
        do_reset();
        step(); step(); step();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h40;
        step();
        branch_taken_i = 1'b0;
        vectors++;
        if (pc_o !== 32'h40 || IF_ID_valid_o !== 1'b0 || IF_ID_instr_o !== 32'h0 || IF_ID_pc_o !== 32'h0 ||
            flush_cnt_o !== 16'd1 || ID_EX_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL branch_flush: pc=%h ifv=%b instr=%h ifpc=%h fc=%0d exv=%b, required pc=40 ifv=0 instr=0 ifpc=0 fc=1 exv=1",
                     pc_o, IF_ID_valid_o, IF_ID_instr_o, IF_ID_pc_o, flush_cnt_o, ID_EX_valid_o);
        end
        $display("branch: pc=%h ifv=%b fc=%0d", pc_o, IF_ID_valid_o, flush_cnt_o);
        step();
        vectors++;
        if (ID_EX_valid_o !== 1'b0 || ID_EX_ctrl_o !== '0 || pc_o !== 32'h44 || IF_ID_valid_o !== 1'b1 ||
            IF_ID_instr_o !== imem(32'h40) || flush_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL branch_bubble: exv=%b ctrl=%h pc=%h ifv=%b instr=%h fc=%0d, required exv=0 ctrl=0 pc=44 ifv=1 instr=%h fc=1",
                     ID_EX_valid_o, ID_EX_ctrl_o, pc_o, IF_ID_valid_o, IF_ID_instr_o, flush_cnt_o, imem(32'h40));
        end
        $display("branch+1: pc=%h exv=%b", pc_o, ID_EX_valid_o);
    endtask

    task automatic test_stall_and_branch();
        do_reset();
        step(); step();
        set_stall(1'b1, 1'b1, 1'b1);
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h80;
        step();
        set_stall(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pc_o !== 32'd8 || flush_cnt_o !== 16'd0 || stall_cnt_o !== 16'd1 || IF_ID_valid_o !== 1'b1 ||
            IF_ID_instr_o !== imem(32'd4)) begin
            errors++;
            $display("FAIL stall_wins: pc=%h fc=%0d sc=%0d ifv=%b instr=%h, required pc=8 fc=0 sc=1 ifv=1 instr=%h",
                     pc_o, flush_cnt_o, stall_cnt_o, IF_ID_valid_o, IF_ID_instr_o, imem(32'd4));
        end
        $display("stall+branch: pc=%h fc=%0d", pc_o, flush_cnt_o);
        step();
        branch_taken_i = 1'b0;
        vectors++;
        if (pc_o !== 32'h80 || flush_cnt_o !== 16'd1 || IF_ID_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL late_redirect: pc=%h fc=%0d ifv=%b, required pc=80 fc=1 ifv=0", pc_o, flush_cnt_o, IF_ID_valid_o);
        end
        $display("redirect: pc=%h fc=%0d", pc_o, flush_cnt_o);
    endtask

    task automatic test_keep_err_and_async_reset();
        do_reset();
        step(); step();
        set_stall(1'b1, 1'b0, 1'b0);
        step();
        set_stall(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pc_o !== 32'd8 || IF_ID_instr_o !== imem(32'd4) || ID_EX_valid_o !== 1'b0 ||
            keep_err_o !== 1'b1 || stall_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL half_keep: pc=%h instr=%h exv=%b err=%b sc=%0d, required pc=8 instr=%h exv=0 err=1 sc=1",
                     pc_o, IF_ID_instr_o, ID_EX_valid_o, keep_err_o, stall_cnt_o, imem(32'd4));
        end
        step();
        vectors++;
        if (keep_err_o !== 1'b1 || pc_o !== 32'd12) begin
            errors++;
            $display("FAIL keep_err_sticky: err=%b pc=%h, required err=1 pc=c", keep_err_o, pc_o);
        end
        $display("keep_err: err=%b pc=%h", keep_err_o, pc_o);
        rst_n_i = 1'b0;
        #1;
        vectors++;
        if (pc_o !== 32'h0 || IF_ID_valid_o !== 1'b0 || IF_ID_instr_o !== 32'h0 || IF_ID_pc_o !== 32'h0 ||
            ID_EX_valid_o !== 1'b0 || ID_EX_ctrl_o !== '0 || stall_cnt_o !== '0 || flush_cnt_o !== '0 ||
            keep_err_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h ifv=%b instr=%h exv=%b sc=%0d err=%b, required all zero",
                     pc_o, IF_ID_valid_o, IF_ID_instr_o, ID_EX_valid_o, stall_cnt_o, keep_err_o);
        end
        $display("async reset: pc=%h err=%b sc=%0d", pc_o, keep_err_o, stall_cnt_o);
        rst_n_i = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        set_stall(1'b1, 1'b1, 1'b1);
        step(); step(); step();
        vectors++;
        if (stall_cnt_o !== 16'd3 || pc_o !== 32'h0) begin
            errors++;
            $display("FAIL stall_count3: sc=%0d pc=%h, required sc=3 pc=0", stall_cnt_o, pc_o);
        end
        repeat ((1 << NW) + 3 - 3) step();
        set_stall(1'b0, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt_o !== 16'hFFFF || pc_o !== 32'h0 || flush_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL stall_saturate: sc=%h pc=%h fc=%0d, required sc=ffff pc=0 fc=0", stall_cnt_o, pc_o, flush_cnt_o);
        end
        $display("saturate: sc=%h", stall_cnt_o);
    endtask

    task automatic test_pc_wrap();
        do_reset();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        step();
        branch_taken_i = 1'b0;
        vectors++;
        if (pc_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_setup: pc=%h, required fffffffc", pc_o);
        end
        step();
        vectors++;
        if (pc_o !== 32'h0 || IF_ID_pc_o !== 32'h0 || IF_ID_instr_o !== imem(32'hFFFF_FFFC) || IF_ID_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h ifpc=%h instr=%h ifv=%b, required pc=0 ifpc=0 instr=%h ifv=1",
                     pc_o, IF_ID_pc_o, IF_ID_instr_o, IF_ID_valid_o, imem(32'hFFFF_FFFC));
        end
        $display("wrap: pc=%h ifpc=%h", pc_o, IF_ID_pc_o);
    endtask

    initial begin
        rst_n_i = 1'b0;
        set_stall(1'b0, 1'b0, 1'b0);
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        ID_ctrl_i       = CTRL_VAL;
        #3;
        test_reset();
        test_sequential();
        test_load_use();
        test_branch_flush();
        test_stall_and_branch();
        test_keep_err_and_async_reset();
        test_saturation();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
